vga_timing_gen: RTL and testbench

- Generates the raster timing stream that the screen controllers consume: hcount/vcount, hsync/vsync and hblnk/vblnk.
- Sits upstream of the top-level screen controller. The menu, game and credits renderers all take their timing from this one source.
- Default geometry is 1024x768@60 (1344x806 total), so UI hit-boxes and mouse coordinates stay in pixel space.
- All outputs are registered. Each output count always matches the flags issued in the same cycle.

---
 rtl/vga_timing_gen.sv | 114 +++++++++++
 tb/tb_vga_timing_gen.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters with registered sync/blank/frame-end flags, all zero-skew to the counts.
// Optional 16-bit frame counter port is enabled with `define VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic        frame_end_out,
  output logic [15:0] frame_cnt_out
`else
  output logic        frame_end_out
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_geometry
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 2048");
    end
  endgenerate

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] HB_START = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VB_START = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0] r_hcount;
  logic [10:0] r_vcount;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_hblnk;
  logic        r_vblnk;
  logic        r_frame_end;

  logic        w_h_wrap;
  logic        w_v_wrap;
  logic [10:0] w_hcount_nxt;
  logic [10:0] w_vcount_nxt;
  logic        w_hsync_act;
  logic        w_vsync_act;

  assign w_h_wrap     = (r_hcount == H_LAST);
  assign w_v_wrap     = (r_vcount == V_LAST);
  assign w_hcount_nxt = w_h_wrap ? 11'd0 : r_hcount + 11'd1;
  assign w_vcount_nxt = w_h_wrap ? (w_v_wrap ? 11'd0 : r_vcount + 11'd1) : r_vcount;

  // Flags decode the next counts so they land in the same register stage as the counts.
  assign w_hsync_act = (w_hcount_nxt >= HS_START) && (w_hcount_nxt <= HS_END);
  assign w_vsync_act = (w_vcount_nxt >= VS_START) && (w_vcount_nxt <= VS_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcount    <= 11'd0;
      r_vcount    <= 11'd0;
      r_hsync     <= ~SYNC_POL;
      r_vsync     <= ~SYNC_POL;
      r_hblnk     <= 1'b0;
      r_vblnk     <= 1'b0;
      r_frame_end <= 1'b0;
    end else begin
      r_hcount    <= w_hcount_nxt;
      r_vcount    <= w_vcount_nxt;
      r_hsync     <= w_hsync_act ? SYNC_POL : ~SYNC_POL;
      r_vsync     <= w_vsync_act ? SYNC_POL : ~SYNC_POL;
      r_hblnk     <= (w_hcount_nxt >= HB_START);
      r_vblnk     <= (w_vcount_nxt >= VB_START);
      r_frame_end <= (w_hcount_nxt == H_LAST) && (w_vcount_nxt == V_LAST);
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= 16'd0;
    end else if (w_h_wrap && w_v_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt_out = r_frame_cnt;
`endif

  assign hcount_out    = r_hcount;
  assign vcount_out    = r_vcount;
  assign hsync_out     = r_hsync;
  assign vsync_out     = r_vsync;
  assign hblnk_out     = r_hblnk;
  assign vblnk_out     = r_vblnk;
  assign frame_end_out = r_frame_end;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default geometry for line timing, a 25x16 geometry (both sync polarities) for frame timing.
module tb_vga_timing_gen;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [10:0] hc_def, vc_def, hc_sml, vc_sml, hc_inv, vc_inv;
  logic        hs_def, vs_def, hb_def, vb_def, fe_def;
  logic        hs_sml, vs_sml, hb_sml, vb_sml, fe_sml;
  logic        hs_inv, vs_inv, hb_inv, vb_inv, fe_inv;
  logic [15:0] fc_def, fc_sml, fc_inv;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst),
    .hcount_out(hc_def), .vcount_out(vc_def),
    .hsync_out(hs_def), .vsync_out(vs_def),
    .hblnk_out(hb_def), .vblnk_out(vb_def),
    .frame_end_out(fe_def)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt_out(fc_def)
`endif
  );

  // Small geometry: H 16/2/3/4 (total 25, hsync 18..20), V 10/1/2/3 (total 16, vsync 11..12).
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
  ) u_sml (
    .clk(clk), .rst(rst),
    .hcount_out(hc_sml), .vcount_out(vc_sml),
    .hsync_out(hs_sml), .vsync_out(vs_sml),
    .hblnk_out(hb_sml), .vblnk_out(vb_sml),
    .frame_end_out(fe_sml)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt_out(fc_sml)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
  ) u_inv (
    .clk(clk), .rst(rst),
    .hcount_out(hc_inv), .vcount_out(vc_inv),
    .hsync_out(hs_inv), .vsync_out(vs_inv),
    .hblnk_out(hb_inv), .vblnk_out(vb_inv),
    .frame_end_out(fe_inv)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt_out(fc_inv)
`endif
  );

`ifndef VGA_TIMING_FRAME_CNT_EN
  initial begin
    fc_def = 16'd0;
    fc_sml = 16'd0;
    fc_inv = 16'd0;
  end
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves rst low at a negedge; all DUTs sit at (0,0) until the next posedge.
  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (hc_def !== 11'd0 || vc_def !== 11'd0 || hb_def !== 1'b0 || vb_def !== 1'b0 ||
        hs_def !== 1'b0 || vs_def !== 1'b0 || fe_def !== 1'b0 || fc_def !== 16'd0) begin
      failures++;
      $display("FAIL reset_def: h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b fe=%b fc=%0d, required all 0",
               hc_def, vc_def, hb_def, vb_def, hs_def, vs_def, fe_def, fc_def);
    end
    checks++;
    if (hs_inv !== 1'b1 || vs_inv !== 1'b1) begin
      failures++;
      $display("FAIL reset_inv_sync: hs=%b vs=%b, required 1 1", hs_inv, vs_inv);
    end
    @(negedge clk);
    rst = 1'b0;
    // 294 cycles puts the small geometry at (19,11): inside both sync pulses.
    for (int i = 1; i <= 294; i++) @(negedge clk);
    checks++;
    if (hc_sml !== 11'd19 || vc_sml !== 11'd11 || hs_sml !== 1'b1 || vs_sml !== 1'b1) begin
      failures++;
      $display("FAIL pre_async_pos: h=%0d v=%0d hs=%b vs=%b, required 19 11 1 1", hc_sml, vc_sml, hs_sml, vs_sml);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (hc_sml !== 11'd0 || vc_sml !== 11'd0 || hs_sml !== 1'b0 || vs_sml !== 1'b0 ||
        hb_sml !== 1'b0 || vb_sml !== 1'b0 || hc_def !== 11'd0 || vc_def !== 11'd0) begin
      failures++;
      $display("FAIL async_reset: h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b def_h=%0d def_v=%0d, required all 0",
               hc_sml, vc_sml, hs_sml, vs_sml, hb_sml, vb_sml, hc_def, vc_def);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (hc_sml !== 11'd1 || vc_sml !== 11'd0 || hs_sml !== 1'b0 || vs_sml !== 1'b0 || hc_def !== 11'd1) begin
      failures++;
      $display("FAIL first_after_reset: h=%0d v=%0d hs=%b vs=%b def_h=%0d, required 1 0 0 0 1",
               hc_sml, vc_sml, hs_sml, vs_sml, hc_def);
    end
  endtask

  task automatic test_horizontal();
    int bad, hs_cnt, hb_rise, h, v;
    bad = 0; hs_cnt = 0; hb_rise = -1;
    release_reset();
    for (int i = 1; i <= 1344; i++) begin
      @(negedge clk);
      h = i % 1344;
      v = i / 1344;
      if (hc_def !== 11'(h) || vc_def !== 11'(v)) bad++;
      if (hb_def !== (h >= 1024)) bad++;
      if (hs_def !== (h >= 1048 && h <= 1183)) bad++;
      if (vb_def !== 1'b0 || vs_def !== 1'b0 || fe_def !== 1'b0) bad++;
      if (hs_def === 1'b1) hs_cnt++;
      if (hb_rise < 0 && hb_def === 1'b1) hb_rise = h;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL horiz_line: %0d wrong samples, required 0", bad);
    end
    checks++;
    if (hs_cnt != 136) begin
      failures++;
      $display("FAIL hsync_width: %0d cycles, required 136", hs_cnt);
    end
    checks++;
    if (hb_rise != 1024) begin
      failures++;
      $display("FAIL hblnk_rise: at h=%0d, required 1024", hb_rise);
    end
    checks++;
    if (hc_def !== 11'd0 || vc_def !== 11'd1 || hb_def !== 1'b0) begin
      failures++;
      $display("FAIL line_wrap: h=%0d v=%0d hb=%b, required 0 1 0", hc_def, vc_def, hb_def);
    end
  endtask

  task automatic test_vertical();
    int bad, vs_cnt, vb_cnt, h, v;
    logic prev_vs, prev_vb;
    bad = 0; vs_cnt = 0; vb_cnt = 0;
    release_reset();
    prev_vs = vs_sml;
    prev_vb = vb_sml;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      h = i % 25;
      v = (i / 25) % 16;
      if (hc_sml !== 11'(h) || vc_sml !== 11'(v)) bad++;
      if (hb_sml !== (h >= 16) || hs_sml !== (h >= 18 && h <= 20)) bad++;
      if (vb_sml !== (v >= 10) || vs_sml !== (v >= 11 && v <= 12)) bad++;
      if (fe_sml !== (h == 24 && v == 15)) bad++;
      if ((vs_sml !== prev_vs || vb_sml !== prev_vb) && h != 0) bad++;
      if (vs_sml === 1'b1) vs_cnt++;
      if (vb_sml === 1'b1) vb_cnt++;
      prev_vs = vs_sml;
      prev_vb = vb_sml;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL vert_frame: %0d wrong samples, required 0", bad);
    end
    checks++;
    if (vs_cnt != 50) begin
      failures++;
      $display("FAIL vsync_width: %0d cycles, required 50", vs_cnt);
    end
    checks++;
    if (vb_cnt != 150) begin
      failures++;
      $display("FAIL vblnk_width: %0d cycles, required 150", vb_cnt);
    end
    checks++;
    if (hc_sml !== 11'd0 || vc_sml !== 11'd0 || vb_sml !== 1'b0) begin
      failures++;
      $display("FAIL frame_wrap: h=%0d v=%0d vb=%b, required 0 0 0", hc_sml, vc_sml, vb_sml);
    end
  endtask

  task automatic test_frame_end();
    int pulses, bad, last;
    pulses = 0; bad = 0; last = -1;
    release_reset();
    for (int i = 1; i <= 1210; i++) begin
      @(negedge clk);
      if (fe_sml === 1'b1) begin
        pulses++;
        if (hc_sml !== 11'd24 || vc_sml !== 11'd15) bad++;
        if (last >= 0 && i - last != 400) bad++;
        last = i;
      end
    end
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL frame_end_count: %0d pulses, required 3", pulses);
    end
    checks++;
    if (bad != 0 || last != 1199) begin
      failures++;
      $display("FAIL frame_end_place: %0d misplaced, last at cycle %0d, required 0 and 1199", bad, last);
    end
  endtask

  task automatic test_polarity();
    int bad;
    bad = 0;
    release_reset();
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (hs_inv !== ~hs_sml || vs_inv !== ~vs_sml) bad++;
      if (hc_inv !== hc_sml || vc_inv !== vc_sml || hb_inv !== hb_sml || vb_inv !== vb_sml) bad++;
      if (hs_inv === 1'b0 && !(hc_sml >= 11'd18 && hc_sml <= 11'd20)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL polarity: %0d wrong samples, required 0", bad);
    end
  endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
  task automatic test_frame_cnt();
    release_reset();
    checks++;
    if (fc_sml !== 16'd0) begin
      failures++;
      $display("FAIL frame_cnt_0: %0d, required 0", fc_sml);
    end
    for (int i = 1; i <= 399; i++) @(negedge clk);
    checks++;
    if (fc_sml !== 16'd0) begin
      failures++;
      $display("FAIL frame_cnt_last_pix: %0d, required 0", fc_sml);
    end
    @(negedge clk);
    checks++;
    if (fc_sml !== 16'd1 || hc_sml !== 11'd0 || vc_sml !== 11'd0) begin
      failures++;
      $display("FAIL frame_cnt_1: cnt=%0d h=%0d v=%0d, required 1 0 0", fc_sml, hc_sml, vc_sml);
    end
    for (int i = 1; i <= 400; i++) @(negedge clk);
    checks++;
    if (fc_sml !== 16'd2 || fc_def !== 16'd0) begin
      failures++;
      $display("FAIL frame_cnt_2: small=%0d default=%0d, required 2 0", fc_sml, fc_def);
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    test_reset();
    test_horizontal();
    test_vertical();
    test_frame_end();
    test_polarity();
`ifdef VGA_TIMING_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
